// File: rtl/serial_subtractor_pkg.sv
// Shared types and constants for the bit-serial subtractor.
package serial_subtractor_pkg;

    // Operand width used when no override is given.
    localparam int DEFAULT_WIDTH = 8;

    // Control states: waiting, consuming one bit per cycle, presenting a result.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/serial_subtractor_if.sv
// Operand/result bundle of the serial subtractor. The master issues
// operands and start; the slave (the subtractor) returns status and result.
interface serial_subtractor_if
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;

    modport master (
        output start, a, b,
        input  busy, done, diff, borrow_out
    );

    modport slave (
        input  start, a, b,
        output busy, done, diff, borrow_out
    );
endinterface

// File: rtl/full_sub.sv
// One-bit full subtractor x - y - bin, built from two gate-level half
// subtractors whose borrows are merged by an OR gate.
module full_sub (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);
    logic d1;
    logic b1;
    logic b2;
    logic x_n;
    logic d1_n;

    // First half subtractor: x - y.
    xor g_hs1_xor (d1, x, y);
    not g_hs1_not (x_n, x);
    and g_hs1_and (b1, x_n, y);

    // Second half subtractor: (x - y) - bin.
    xor g_hs2_xor (d, d1, bin);
    not g_hs2_not (d1_n, d1);
    and g_hs2_and (b2, d1_n, bin);

    // A borrow from either stage propagates out.
    or  g_bout_or (bout, b1, b2);
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: computes a - b one bit per cycle, LSB
// first, and publishes diff/borrow_out only when all WIDTH bits are done.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                clk,
    input  logic                rst_n,
    serial_subtractor_if.slave  bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    // Holds the WIDTH-1 most recent result bits; the final bit is merged
    // in on the completing edge straight into diff.
    logic [WIDTH-2:0]   res_q, res_d;
    logic               borrow_q, borrow_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   diff_q, diff_d;
    logic               borrow_out_q, borrow_out_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               bit_d;
    logic               bit_bout;
    logic [WIDTH-1:0]   shifted;
    logic               last_bit;

    full_sub u_full_sub (
        .x    (a_q[0]),
        .y    (b_q[0]),
        .bin  (borrow_q),
        .d    (bit_d),
        .bout (bit_bout)
    );

    // Result register after shifting in the current difference bit.
    assign shifted  = {bit_d, res_q};
    assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

    // Next-state and datapath decisions for one clock cycle.
    always_comb begin
        // NOTE: every _d starts at its held value so no path leaves a
        // signal unassigned, which would otherwise infer a latch.
        state_d      = state_q;
        a_d          = a_q;
        b_d          = b_q;
        res_d        = res_q;
        borrow_d     = borrow_q;
        cnt_d        = cnt_q;
        diff_d       = diff_q;
        borrow_out_d = borrow_out_q;

        case (state_q)
            IDLE, DONE: begin
                // A result cycle accepts a new start exactly like idle.
                if (bus.start) begin
                    a_d      = bus.a;
                    b_d      = bus.b;
                    res_d    = '0;
                    borrow_d = 1'b0;
                    cnt_d    = '0;
                    state_d  = SHIFT;
                end else begin
                    state_d  = IDLE;
                end
            end
            SHIFT: begin
                // start is deliberately not looked at while bits are in flight.
                res_d    = shifted[WIDTH-1:1];
                a_d      = a_q >> 1;
                b_d      = b_q >> 1;
                borrow_d = bit_bout;
                cnt_d    = cnt_q + CNT_W'(1);
                if (last_bit) begin
                    diff_d       = shifted;
                    borrow_out_d = bit_bout;
                    state_d      = DONE;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == SHIFT);
        done_d = (state_d == DONE);
    end

    // All state, including registered status outputs, updates here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the operand/result shift registers are reset as well, so
            // an operation abandoned by reset leaves nothing behind.
            state_q      <= IDLE;
            a_q          <= '0;
            b_q          <= '0;
            res_q        <= '0;
            borrow_q     <= 1'b0;
            cnt_q        <= '0;
            diff_q       <= '0;
            borrow_out_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            // NOTE: non-blocking updates so every flop samples pre-edge values.
            state_q      <= state_d;
            a_q          <= a_d;
            b_q          <= b_d;
            res_q        <= res_d;
            borrow_q     <= borrow_d;
            cnt_q        <= cnt_d;
            diff_q       <= diff_d;
            borrow_out_q <= borrow_out_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.diff       = diff_q;
    assign bus.borrow_out = borrow_out_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: a WIDTH=8 unit for directed and random
// operations and a WIDTH=4 unit for the full operand sweep. A cycle-level
// reference model queues expected results on every accepted start; a
// monitor pops them on each done pulse and checks status every cycle.
module tb_serial_subtractor;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic       start_s [2];
    logic [7:0] a_s     [2];
    logic [7:0] b_s     [2];
    logic       busy_s  [2];
    logic       done_s  [2];
    logic       bout_s  [2];
    logic [7:0] diff_s  [2];

    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] required);
        checks++;
        if (actual !== required) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, actual, required, $time);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_u
        localparam int W = (g == 0) ? 8 : 4;

        serial_subtractor_if #(.WIDTH(W)) bus ();

        assign bus.start = start_s[g];
        assign bus.a     = a_s[g][W-1:0];
        assign bus.b     = b_s[g][W-1:0];
        assign busy_s[g] = bus.busy;
        assign done_s[g] = bus.done;
        assign bout_s[g] = bus.borrow_out;
        assign diff_s[g] = 8'(bus.diff);

        serial_subtractor #(.WIDTH(W)) dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (bus.slave)
        );

        logic [W:0] exp_q [$];
        int         rem;
        bit         fin;
        logic [W:0] last;

        // Reference: unsigned a-b modulo 2^W, borrow when a<b.
        function automatic logic [W:0] ref_sub(input int x, input int y);
            int m;
            m = 1 << W;
            return {(x < y) ? 1'b1 : 1'b0, W'((x - y + m) % m)};
        endfunction

        // Model: a start while free is taken; the result is due W cycles later.
        initial begin
            rem = 0;
            fin = 1'b0;
            forever begin
                @(posedge clk or negedge rst_n);
                if (!rst_n) begin
                    exp_q.delete();
                    rem = 0;
                    fin = 1'b0;
                end else if (rem > 0) begin
                    rem--;
                    fin = (rem == 0);
                end else begin
                    fin = 1'b0;
                    if (start_s[g] === 1'b1) begin
                        exp_q.push_back(ref_sub(int'(a_s[g][W-1:0]), int'(b_s[g][W-1:0])));
                        rem = W;
                    end
                end
            end
        end

        // Monitor: status every cycle, result popped on each done pulse.
        initial begin
            last = '0;
            forever begin
                @(negedge clk or negedge rst_n);
                if (!rst_n) begin
                    last = '0;
                end else begin
                    check($sformatf("w%0d busy", W), 32'(busy_s[g]), 32'(rem > 0));
                    check($sformatf("w%0d done", W), 32'(done_s[g]), 32'(fin));
                    if (done_s[g] === 1'b1 && exp_q.size() > 0) last = exp_q.pop_front();
                    check($sformatf("w%0d diff", W), 32'(diff_s[g]), 32'(last[W-1:0]));
                    check($sformatf("w%0d borrow_out", W), 32'(bout_s[g]), 32'(last[W]));
                end
            end
        end
    end

    task automatic issue_now(input int u, input int x, input int y);
        start_s[u] = 1'b1;
        a_s[u]     = 8'(x);
        b_s[u]     = 8'(y);
        @(negedge clk);
        start_s[u] = 1'b0;
    endtask

    task automatic issue(input int u, input int x, input int y);
        @(negedge clk);
        issue_now(u, x, y);
    endtask

    task automatic wait_done(input int u, input int budget, output int n);
        n = 0;
        while (done_s[u] !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("u%0d done within budget", u), 32'(done_s[u]), 32'd1);
    endtask

    int da [3] = '{5, 0, 255};
    int db [3] = '{10, 255, 255};
    int dd [3] = '{251, 1, 0};
    int dbo[3] = '{1, 1, 0};

    initial begin
        int n;
        int seen;
        int last_idx;
        int n_done;
        bit at_done;

        rst_n   = 1'b0;
        start_s = '{1'b0, 1'b0};
        a_s     = '{8'd0, 8'd0};
        b_s     = '{8'd0, 8'd0};
        repeat (2) @(negedge clk);
        check("reset busy", 32'(busy_s[0]), 32'd0);
        check("reset done", 32'(done_s[0]), 32'd0);
        check("reset diff", 32'(diff_s[0]), 32'd0);
        check("reset borrow_out", 32'(bout_s[0]), 32'd0);
        rst_n = 1'b1;

        // 100 - 37, with latency from the accepting edge.
        issue(0, 100, 37);
        wait_done(0, 20, n);
        check("latency 100-37", 32'(n), 32'd8);
        check("diff 100-37", 32'(diff_s[0]), 32'd63);
        check("borrow 100-37", 32'(bout_s[0]), 32'd0);

        // Borrow and equality corners.
        for (int i = 0; i < 3; i++) begin
            issue(0, da[i], db[i]);
            wait_done(0, 20, n);
            check($sformatf("diff %0d-%0d", da[i], db[i]), 32'(diff_s[0]), 32'(dd[i]));
            check($sformatf("borrow %0d-%0d", da[i], db[i]), 32'(bout_s[0]), 32'(dbo[i]));
        end

        // start during the 3rd shift cycle must be ignored.
        issue(0, 200, 1);
        repeat (2) @(negedge clk);
        issue_now(0, 9, 9);
        wait_done(0, 20, n);
        check("latency with ignored start", 32'(n + 3), 32'd8);
        check("diff 200-1", 32'(diff_s[0]), 32'd199);
        check("borrow 200-1", 32'(bout_s[0]), 32'd0);

        // Reset in the 4th shift cycle clears outputs without a clock.
        issue(0, 50, 20);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async reset busy", 32'(busy_s[0]), 32'd0);
        check("async reset done", 32'(done_s[0]), 32'd0);
        check("async reset diff", 32'(diff_s[0]), 32'd0);
        check("async reset borrow_out", 32'(bout_s[0]), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (done_s[0] === 1'b1) seen = 1;
        end
        check("no done after reset", 32'(seen), 32'd0);
        issue(0, 50, 20);
        wait_done(0, 20, n);
        check("diff 50-20", 32'(diff_s[0]), 32'd30);

        // start held high: DONE re-accepts, one result every 9 cycles.
        @(negedge clk);
        start_s[0] = 1'b1;
        a_s[0]     = 8'd7;
        b_s[0]     = 8'd3;
        last_idx   = -1;
        n_done     = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            check("busy low only in done", 32'(busy_s[0]), 32'(!done_s[0]));
            if (done_s[0] === 1'b1) begin
                if (last_idx >= 0) check("done period", 32'(i - last_idx), 32'd9);
                check("diff 7-3", 32'(diff_s[0]), 32'd4);
                last_idx = i;
                n_done++;
            end
        end
        start_s[0] = 1'b0;
        check("done count with start held", 32'(n_done), 32'd4);
        wait_done(0, 20, n);

        // Random operands, sometimes chained straight from the done cycle.
        at_done = 1'b1;
        repeat (40) begin
            if (at_done && $urandom_range(0, 1) == 1) begin
                issue_now(0, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
            end else begin
                repeat ($urandom_range(0, 2)) @(negedge clk);
                issue(0, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
            end
            wait_done(0, 20, n);
            at_done = (done_s[0] === 1'b1);
        end

        // Every 4-bit operand pair, back to back.
        for (int p = 0; p < 256; p++) begin
            if (p == 0) issue(1, p >> 4, p & 15);
            else        issue_now(1, p >> 4, p & 15);
            wait_done(1, 20, n);
        end
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
